// File: rtl/flow_source_pkg.sv
// Shared definitions for the flow_source transmit block: lane geometry and
// the global state encoding also used by the fsm bench checks.
package flow_source_pkg;

  localparam int NUM_CH     = 4;
  localparam int DATA_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_ERROR = 2'b10
  } state_t;

  localparam logic [1:0] RR_PTR_RESET = 2'd3;

  // pausa sets a lane's paused flag and wins over a simultaneous continuar.
  function automatic logic [NUM_CH-1:0] next_pause(
    input logic [NUM_CH-1:0] cur,
    input logic [NUM_CH-1:0] pausa,
    input logic [NUM_CH-1:0] continuar
  );
    return (cur & ~continuar) | pausa;
  endfunction

endpackage

// File: rtl/flow_source_rr_arbiter.sv
// Combinational rotate-priority encoder: the lane after ptr has top priority,
// and ptr itself comes last.
module rr_arbiter (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic [1:0] idx;

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    gnt_idx = ptr;
    idx     = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        gnt_idx = idx;
      end
    end
    gnt = (|req) ? (4'b0001 << gnt_idx) : 4'b0000;
  end

endmodule

// File: rtl/flow_source.sv
// Transmit-side flow source: round-robin merges four valid/ready lanes onto
// one registered push port, obeying per-lane pause and global overflow error.
module flow_source
  import flow_source_pkg::*;
#(
  parameter int DATA_WIDTH = flow_source_pkg::DATA_WIDTH,
  parameter int NUM_CH     = flow_source_pkg::NUM_CH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iniciar,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH-1:0]            pausa,
  input  logic [NUM_CH-1:0]            continuar,
  input  logic                         error_full,
  output logic                         push,
  output logic [DATA_WIDTH-1:0]        push_data,
  output logic [1:0]                   push_dest,
  output logic [NUM_CH-1:0]            pausado,
  output logic [1:0]                   estado,
  output logic                         idle
);

  state_t                  state;
  logic [1:0]              rr_ptr;
  logic [NUM_CH-1:0]       eligible;
  logic [NUM_CH-1:0]       gnt;
  logic [1:0]              gnt_idx;
  logic                    granted;
  logic [DATA_WIDTH-1:0]   lane_word [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign lane_word[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Registered pausado gates eligibility, so a pausa lets at most one more word in.
  assign eligible = (state == ST_RUN) ? (in_valid & ~pausado) : '0;

  rr_arbiter u_arb (
    .req     (eligible),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign granted  = |gnt;
  assign in_ready = gnt;
  assign estado   = state;
  assign idle     = (state == ST_IDLE) ||
                    ((state == ST_RUN) && (in_valid == '0) && !push);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pausado   <= '0;
      rr_ptr    <= RR_PTR_RESET;
      push      <= 1'b0;
      push_data <= '0;
      push_dest <= '0;
    end else begin
      pausado <= next_pause(pausado, pausa, continuar);

      unique case (state)
        ST_IDLE:  if (iniciar) state <= ST_RUN;
        ST_RUN:   if (error_full) state <= ST_ERROR;
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_IDLE;
      endcase

      push <= granted;
      if (granted) begin
        rr_ptr    <= gnt_idx;
        push_data <= lane_word[gnt_idx];
        push_dest <= gnt_idx;
      end
    end
  end

endmodule
